// File: rtl/ls_wb_pipe_pkg.sv
// Shared definitions for the LSU -> CSR/WB pipeline register: CSR address map,
// csr_wfunc encodings, FSM state type and payload width helper.
package ls_wb_pipe_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    localparam logic [1:0] CSR_WFUNC_NONE  = 2'b00;
    localparam logic [1:0] CSR_WFUNC_WRITE = 2'b01;
    localparam logic [1:0] CSR_WFUNC_SET   = 2'b10;
    localparam logic [1:0] CSR_WFUNC_CLEAR = 2'b11;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } ls_wb_state_e;

    // Fixed-width control fields: unusual, wfunc, CSR addr/ren/wen, rd addr/wen.
    localparam int PAY_CTRL_W = 23;

    function automatic int ls_wb_pay_width(input int data_len);
        return 4 * data_len + PAY_CTRL_W;
    endfunction

endpackage

// File: rtl/ls_wb_entry.sv
// One payload slot of the LSU -> CSR/WB pipeline: load-enabled register with
// synchronous clear (clear wins over load) and asynchronous reset to zero.
module ls_wb_entry
    import ls_wb_pipe_pkg::*;
#(
    parameter int WIDTH = 151
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;

    // Slot storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= '0;
        end else if (clear) begin
            q_r <= '0;
        end else if (load) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/ls_wb_pipe.sv
// LSU -> CSR/WB pipeline register with trap hold. Define LS_WB_SKID_EN for a
// two-entry skid buffer with a registered lsu_ready; otherwise a single register.
module ls_wb_pipe
    import ls_wb_pipe_pkg::*;
#(
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                lsu_valid,
    output logic                lsu_ready,
    input  logic                lsu_unusual_flag,
    input  logic [DATA_LEN-1:0] lsu_csr_wdata,
    input  logic [DATA_LEN-1:0] lsu_cause,
    input  logic [DATA_LEN-1:0] lsu_PC,
    input  logic [1:0]          lsu_csr_wfunc,
    input  logic [11:0]         lsu_CSR_addr,
    input  logic                lsu_CSR_ren,
    input  logic                lsu_CSR_wen,
    input  logic [DATA_LEN-1:0] lsu_rd_wdata,
    input  logic [4:0]          lsu_rd_addr,
    input  logic                lsu_rd_wen,
    output logic                LS_WB_reg_ls_valid,
    output logic                LS_WB_reg_unusual_flag,
    output logic [DATA_LEN-1:0] LS_WB_reg_csr_wdata,
    output logic [DATA_LEN-1:0] LS_WB_reg_cause,
    output logic [DATA_LEN-1:0] LS_WB_reg_PC,
    output logic [1:0]          LS_WB_reg_csr_wfunc,
    output logic [11:0]         LS_WB_reg_CSR_addr,
    output logic                LS_WB_reg_CSR_ren,
    output logic                LS_WB_reg_CSR_wen,
    output logic [DATA_LEN-1:0] LS_WB_reg_rd_wdata,
    output logic [4:0]          LS_WB_reg_rd_addr,
    output logic                LS_WB_reg_rd_wen,
    input  logic                wb_ready,
    input  logic                flush,
    output logic                trap_hold
);

    localparam int PAY_W = ls_wb_pay_width(DATA_LEN);

    ls_wb_state_e     state_r;
    ls_wb_state_e     state_nxt_s;
    logic             trap_hold_s;
    logic             accept_s;
    logic             consume_s;
    logic             head_valid_r;
    logic             head_valid_nxt_s;
    logic             head_load_s;
    logic             head_clear_s;
    logic [PAY_W-1:0] in_pay_s;
    logic [PAY_W-1:0] head_d_s;
    logic [PAY_W-1:0] head_q_s;

    assign in_pay_s = {lsu_unusual_flag, lsu_csr_wdata, lsu_cause, lsu_PC,
                       lsu_csr_wfunc, lsu_CSR_addr, lsu_CSR_ren, lsu_CSR_wen,
                       lsu_rd_wdata, lsu_rd_addr, lsu_rd_wen};

    // lsu_ready is already low under flush, so a flushed cycle never accepts.
    assign accept_s  = lsu_valid & lsu_ready;
    assign consume_s = head_valid_r & wb_ready;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: a trap entry freezes intake until the redirect flush
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (accept_s && lsu_unusual_flag) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // FSM outputs
    always_comb begin
        trap_hold_s = 1'b0;
        case (state_r)
            ST_RUN:  trap_hold_s = 1'b0;
            ST_HOLD: trap_hold_s = 1'b1;
            default: trap_hold_s = 1'b0;
        endcase
    end

    assign trap_hold = trap_hold_s;

`ifdef LS_WB_SKID_EN
    logic             skid_valid_r;
    logic             skid_valid_nxt_s;
    logic             skid_load_s;
    logic             skid_clear_s;
    logic [PAY_W-1:0] skid_q_s;
    logic             ready_r;
    logic             head_open_s;

    assign head_open_s = ~head_valid_r | wb_ready;
    assign lsu_ready   = ready_r & rst_n & ~flush;

    // Skid steering: head refills from skid first, then from upstream
    always_comb begin
        head_load_s      = 1'b0;
        head_clear_s     = 1'b0;
        head_d_s         = in_pay_s;
        head_valid_nxt_s = head_valid_r;
        skid_load_s      = 1'b0;
        skid_clear_s     = 1'b0;
        skid_valid_nxt_s = skid_valid_r;
        if (flush) begin
            head_clear_s     = 1'b1;
            head_valid_nxt_s = 1'b0;
            skid_clear_s     = 1'b1;
            skid_valid_nxt_s = 1'b0;
        end else if (head_open_s) begin
            if (skid_valid_r) begin
                head_load_s      = 1'b1;
                head_d_s         = skid_q_s;
                head_valid_nxt_s = 1'b1;
                skid_clear_s     = 1'b1;
                skid_valid_nxt_s = 1'b0;
            end else if (accept_s) begin
                head_load_s      = 1'b1;
                head_valid_nxt_s = 1'b1;
            end else begin
                head_clear_s     = 1'b1;
                head_valid_nxt_s = 1'b0;
            end
        end else if (accept_s) begin
            skid_load_s      = 1'b1;
            skid_valid_nxt_s = 1'b1;
        end else begin
            skid_valid_nxt_s = skid_valid_r;
        end
    end

    // Skid valid bit and registered ready (skid empty and RUN after this edge)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid_r <= 1'b0;
            ready_r      <= 1'b1;
        end else begin
            skid_valid_r <= skid_valid_nxt_s;
            ready_r      <= ~skid_valid_nxt_s & (state_nxt_s == ST_RUN);
        end
    end

    ls_wb_entry #(.WIDTH(PAY_W)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load_s),
        .clear (skid_clear_s),
        .d     (in_pay_s),
        .q     (skid_q_s)
    );
`else
    assign lsu_ready = rst_n & ~flush & ~trap_hold_s & (~head_valid_r | wb_ready);
    assign head_d_s  = in_pay_s;

    // Single-register steering: load on accept, clear when drained or flushed
    always_comb begin
        head_load_s      = 1'b0;
        head_clear_s     = 1'b0;
        head_valid_nxt_s = head_valid_r;
        if (flush) begin
            head_clear_s     = 1'b1;
            head_valid_nxt_s = 1'b0;
        end else if (accept_s) begin
            head_load_s      = 1'b1;
            head_valid_nxt_s = 1'b1;
        end else if (consume_s) begin
            head_clear_s     = 1'b1;
            head_valid_nxt_s = 1'b0;
        end else begin
            head_valid_nxt_s = head_valid_r;
        end
    end
`endif

    // Head valid bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_valid_r <= 1'b0;
        end else begin
            head_valid_r <= head_valid_nxt_s;
        end
    end

    ls_wb_entry #(.WIDTH(PAY_W)) u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (head_load_s),
        .clear (head_clear_s),
        .d     (head_d_s),
        .q     (head_q_s)
    );

    assign LS_WB_reg_ls_valid = head_valid_r;
    assign {LS_WB_reg_unusual_flag, LS_WB_reg_csr_wdata, LS_WB_reg_cause, LS_WB_reg_PC,
            LS_WB_reg_csr_wfunc, LS_WB_reg_CSR_addr, LS_WB_reg_CSR_ren, LS_WB_reg_CSR_wen,
            LS_WB_reg_rd_wdata, LS_WB_reg_rd_addr, LS_WB_reg_rd_wen} = head_q_s;

endmodule

// File: tb/tb_ls_wb_pipe.sv
// Self-checking bench for ls_wb_pipe: vector table, directed corner sequences
// and randomized traffic against a queue-based reference (either build).
module tb_ls_wb_pipe;

    localparam int D = 32;
`ifdef LS_WB_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    typedef struct packed {
        logic         unusual;
        logic [D-1:0] csr_wdata;
        logic [D-1:0] cause;
        logic [D-1:0] pc;
        logic [1:0]   wfunc;
        logic [11:0]  csr_addr;
        logic         ren;
        logic         wen;
        logic [D-1:0] rd_wdata;
        logic [4:0]   rd_addr;
        logic         rd_wen;
    } pay_t;

    typedef struct {
        logic         lsu_valid;
        logic [D-1:0] pc;
        logic         wb_ready;
        logic         exp_valid;
        logic [D-1:0] exp_pc;
        logic         exp_ready;
    } vec_t;

    logic clk, rst_n, lsu_valid, wb_ready, flush;
    pay_t drv;
    logic lsu_ready, out_valid, trap_hold;
    logic         g_unusual, g_ren, g_wen, g_rd_wen;
    logic [D-1:0] g_csr_wdata, g_cause, g_pc, g_rd_wdata;
    logic [1:0]   g_wfunc;
    logic [11:0]  g_csr_addr;
    logic [4:0]   g_rd_addr;
    pay_t got;

    int n_checks;
    int n_fail;

    pay_t mq[$];
    bit   m_hold;

    ls_wb_pipe #(.DATA_LEN(D)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .lsu_valid              (lsu_valid),
        .lsu_ready              (lsu_ready),
        .lsu_unusual_flag       (drv.unusual),
        .lsu_csr_wdata          (drv.csr_wdata),
        .lsu_cause              (drv.cause),
        .lsu_PC                 (drv.pc),
        .lsu_csr_wfunc          (drv.wfunc),
        .lsu_CSR_addr           (drv.csr_addr),
        .lsu_CSR_ren            (drv.ren),
        .lsu_CSR_wen            (drv.wen),
        .lsu_rd_wdata           (drv.rd_wdata),
        .lsu_rd_addr            (drv.rd_addr),
        .lsu_rd_wen             (drv.rd_wen),
        .LS_WB_reg_ls_valid     (out_valid),
        .LS_WB_reg_unusual_flag (g_unusual),
        .LS_WB_reg_csr_wdata    (g_csr_wdata),
        .LS_WB_reg_cause        (g_cause),
        .LS_WB_reg_PC           (g_pc),
        .LS_WB_reg_csr_wfunc    (g_wfunc),
        .LS_WB_reg_CSR_addr     (g_csr_addr),
        .LS_WB_reg_CSR_ren      (g_ren),
        .LS_WB_reg_CSR_wen      (g_wen),
        .LS_WB_reg_rd_wdata     (g_rd_wdata),
        .LS_WB_reg_rd_addr      (g_rd_addr),
        .LS_WB_reg_rd_wen       (g_rd_wen),
        .wb_ready               (wb_ready),
        .flush                  (flush),
        .trap_hold              (trap_hold)
    );

    assign got = {g_unusual, g_csr_wdata, g_cause, g_pc, g_wfunc, g_csr_addr,
                  g_ren, g_wen, g_rd_wdata, g_rd_addr, g_rd_wen};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply inputs after the falling edge, settle, leave caller to check.
    task automatic drive(input logic v, input pay_t p, input logic wb, input logic fl);
        @(negedge clk);
        lsu_valid = v;
        drv       = p;
        wb_ready  = wb;
        flush     = fl;
        #1;
    endtask

    function automatic pay_t mk(input logic [D-1:0] pc);
        pay_t p;
        p    = '0;
        p.pc = pc;
        return p;
    endfunction

    initial begin
        vec_t vecs[13];
        pay_t p;
        int   oi;
        n_checks = 0;
        n_fail   = 0;

        // Sustained one-per-cycle stream starting at 0x80000000, then drain.
        for (int i = 0; i < 13; i++) begin
            vecs[i].lsu_valid = (i <= 10);
            vecs[i].pc        = 32'h8000_0000 + 32'(4 * i);
            vecs[i].wb_ready  = 1'b1;
            vecs[i].exp_valid = (i >= 1 && i <= 11);
            vecs[i].exp_pc    = vecs[i].exp_valid ? 32'h8000_0000 + 32'(4 * (i - 1)) : 32'h0;
            vecs[i].exp_ready = 1'b1;
        end

        // Reset state
        rst_n = 1'b0; lsu_valid = 1'b0; wb_ready = 1'b0; flush = 1'b0; drv = '0;
        #2;
        chk("rst_valid", 160'(out_valid), 160'(1'b0));
        chk("rst_ready", 160'(lsu_ready), 160'(1'b0));
        chk("rst_trap",  160'(trap_hold), 160'(1'b0));
        chk("rst_pay",   160'(got),       160'(0));
        #5;
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b1);
        chk("rel_flush_ready", 160'(lsu_ready), 160'(1'b0));
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("rel_ready", 160'(lsu_ready), 160'(1'b1));

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].lsu_valid, mk(vecs[i].pc), vecs[i].wb_ready, 1'b0);
            chk($sformatf("vec%0d_valid", i), 160'(out_valid), 160'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_pc", i),    160'(g_pc),      160'(vecs[i].exp_pc));
            chk($sformatf("vec%0d_ready", i), 160'(lsu_ready), 160'(vecs[i].exp_ready));
        end

        // Backpressure: three entries offered while wb_ready=0 for 5 cycles.
        oi = 0;
        for (int c = 0; c < 5; c++) begin
            logic er;
            er = (c == 0) || (c == 1 && CAP == 2);
            drive(1'b1, mk(32'h100 + 32'(4 * oi)), 1'b0, 1'b0);
            chk($sformatf("bp%0d_valid", c), 160'(out_valid), 160'(c > 0));
            chk($sformatf("bp%0d_pc", c),    160'(g_pc),      160'((c > 0) ? 32'h100 : 32'h0));
            chk($sformatf("bp%0d_ready", c), 160'(lsu_ready), 160'(er));
            if (er) oi++;
        end
        for (int d = 0; d <= CAP; d++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            chk($sformatf("bpdrain%0d_valid", d), 160'(out_valid), 160'(d < CAP));
            chk($sformatf("bpdrain%0d_pc", d), 160'(g_pc),
                160'((d < CAP) ? 32'h100 + 32'(4 * d) : 32'h0));
        end

        // Trap entry: hold until flush.
        p = mk(32'h300); p.unusual = 1'b1; p.cause = 32'd2;
        drive(1'b1, p, 1'b1, 1'b0);
        chk("trap_pre_ready", 160'(lsu_ready), 160'(1'b1));
        drive(1'b1, mk(32'h304), 1'b1, 1'b0);
        chk("trap_hold1", 160'(trap_hold), 160'(1'b1));
        chk("trap_ready1", 160'(lsu_ready), 160'(1'b0));
        chk("trap_valid1", 160'(out_valid), 160'(1'b1));
        chk("trap_cause1", 160'(g_cause), 160'(32'd2));
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("trap_valid2", 160'(out_valid), 160'(1'b0));
        chk("trap_cause2", 160'(g_cause), 160'(32'd0));
        chk("trap_hold2", 160'(trap_hold), 160'(1'b1));
        chk("trap_ready2", 160'(lsu_ready), 160'(1'b0));
        drive(1'b0, '0, 1'b1, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("trap_hold3", 160'(trap_hold), 160'(1'b0));
        chk("trap_ready3", 160'(lsu_ready), 160'(1'b1));

        // Flush with full buffer and a simultaneous offer.
        for (int c = 0; c < CAP; c++) drive(1'b1, mk(32'h400 + 32'(4 * c)), 1'b0, 1'b0);
        drive(1'b1, mk(32'hDEAD_0000), 1'b0, 1'b1);
        chk("fl_pre_valid", 160'(out_valid), 160'(1'b1));
        chk("fl_pre_pc", 160'(g_pc), 160'(32'h400));
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            chk($sformatf("fl%0d_valid", k), 160'(out_valid), 160'(1'b0));
            chk($sformatf("fl%0d_pay", k), 160'(got), 160'(0));
        end

        // Asynchronous reset pulse while full with a trap entry buffered.
        for (int c = 0; c < CAP; c++) begin
            p = mk(32'h500 + 32'(4 * c)); p.wen = 1'b1; p.unusual = (c == CAP - 1);
            drive(1'b1, p, 1'b0, 1'b0);
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("ar_pre_valid", 160'(out_valid), 160'(1'b1));
        chk("ar_pre_wen", 160'(g_wen), 160'(1'b1));
        chk("ar_pre_trap", 160'(trap_hold), 160'(1'b1));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 160'(out_valid), 160'(1'b0));
        chk("ar_wen", 160'(g_wen), 160'(1'b0));
        chk("ar_trap", 160'(trap_hold), 160'(1'b0));
        chk("ar_pay", 160'(got), 160'(0));
        #4;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            chk($sformatf("ar_post%0d_valid", k), 160'(out_valid), 160'(1'b0));
        end

        // Randomized traffic against the occupancy/queue reference.
        mq.delete();
        m_hold = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            pay_t rp, ep;
            logic rv, rw, rf, er, ev;
            rp.unusual   = ($urandom_range(15) == 0);
            rp.csr_wdata = $urandom;
            rp.cause     = $urandom;
            rp.pc        = $urandom;
            rp.wfunc     = 2'($urandom_range(3));
            rp.csr_addr  = 12'($urandom);
            rp.ren       = 1'($urandom_range(1));
            rp.wen       = 1'($urandom_range(1));
            rp.rd_wdata  = $urandom;
            rp.rd_addr   = 5'($urandom);
            rp.rd_wen    = 1'($urandom_range(1));
            rv = ($urandom_range(3) != 0);
            rw = 1'($urandom_range(1));
            rf = ($urandom_range(24) == 0);
            drive(rv, rp, rw, rf);
            ev = (mq.size() > 0);
            if (ev) ep = mq[0];
            else    ep = '0;
            er = !m_hold && !rf && ((CAP == 2) ? (mq.size() < 2) : (mq.size() == 0 || rw));
            chk("rand_valid", 160'(out_valid), 160'(ev));
            chk("rand_pay",   160'(got),       160'(ep));
            chk("rand_trap",  160'(trap_hold), 160'(m_hold));
            if (!rf) chk("rand_ready", 160'(lsu_ready), 160'(er));
            if (rf) begin
                mq.delete();
                m_hold = 1'b0;
            end else begin
                if (ev && rw) void'(mq.pop_front());
                if (rv && er) begin
                    mq.push_back(rp);
                    if (rp.unusual) m_hold = 1'b1;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ls_wb_pipe.md
LS_WB_PIPE -- requirements
Module: ls_wb_pipe

Interface
REQ-001 SHALL have parameter DATA_LEN, default 32, giving the datapath width (32 or 64).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have port lsu_valid  in  1  upstream entry present.
REQ-005 SHALL have port lsu_ready  out  1  block accepts the upstream entry this cycle.
REQ-006 SHALL have the upstream payload inputs lsu_unusual_flag 1, lsu_csr_wdata DATA_LEN, lsu_cause DATA_LEN, lsu_PC DATA_LEN, lsu_csr_wfunc 2, lsu_CSR_addr 12, lsu_CSR_ren 1, lsu_CSR_wen 1, lsu_rd_wdata DATA_LEN, lsu_rd_addr 5 and lsu_rd_wen 1.
REQ-007 SHALL have port LS_WB_reg_ls_valid  out  1  the head entry is valid toward the CSR/WB stage.
REQ-008 SHALL have the head-entry payload outputs LS_WB_reg_unusual_flag, LS_WB_reg_csr_wdata, LS_WB_reg_cause, LS_WB_reg_PC, LS_WB_reg_csr_wfunc, LS_WB_reg_CSR_addr, LS_WB_reg_CSR_ren, LS_WB_reg_CSR_wen, LS_WB_reg_rd_wdata, LS_WB_reg_rd_addr and LS_WB_reg_rd_wen, with widths matching REQ-006.
REQ-009 SHALL have port wb_ready  in  1  downstream consumes the head entry this cycle.
REQ-010 SHALL have port flush  in  1  pipeline flush from the trap/redirect logic.
REQ-011 SHALL have port trap_hold  out  1  a trap entry has been accepted and no flush has arrived yet.

Function
REQ-012 SHALL transfer an entry upstream exactly when lsu_valid&lsu_ready at a clock edge, and downstream exactly when LS_WB_reg_ls_valid&wb_ready at a clock edge.
REQ-013 SHALL present an accepted entry on LS_WB_reg_* on the cycle after acceptance when the block was empty (latency 1).
REQ-014 SHALL deliver entries in order, without loss or duplication, and SHALL NOT change LS_WB_reg_* while LS_WB_reg_ls_valid=1 and wb_ready=0.
REQ-015 SHALL keep LS_WB_reg_* at all-zero whenever LS_WB_reg_ls_valid=0, so the CSR block never sees a stray CSR_wen or unusual_flag.
REQ-016 SHALL use a two-state FSM: RUN, and HOLD (trap_hold=1).
- RUN->HOLD on acceptance of an entry with lsu_unusual_flag=1.
- HOLD->RUN on flush.
REQ-017 SHALL hold lsu_ready=0 while in HOLD; entries already buffered still drain.
REQ-018 SHALL, on flush=1 at a clock edge: invalidate every buffered entry, drop any simultaneous upstream transfer, and enter RUN.
- A head entry with wb_ready=1 in that same cycle counts as consumed.
REQ-019 SHALL, on simultaneous accept and consume while full, leave the occupancy unchanged.
REQ-020 SHALL assert lsu_ready=0 during reset and in the first cycle after reset release only if flush=1; otherwise lsu_ready=1.

Reset
REQ-021 SHALL, while rst_n=0, asynchronously clear every valid bit and every payload register to zero and force the FSM to RUN.
- Resulting outputs: LS_WB_reg_ls_valid=0, trap_hold=0, all LS_WB_reg_* = 0.
REQ-022 SHALL discard any entry in flight when reset asserts mid-operation; nothing is replayed after release.

Configuration
REQ-023 SHALL recognise macro LS_WB_SKID_EN.
- Defined: two-entry skid buffer. lsu_ready is driven directly by a flop (= skid entry empty and FSM in RUN), with no combinational path from wb_ready. Occupancy 0..2.
- Undefined: single register. lsu_ready = (~LS_WB_reg_ls_valid | wb_ready) & RUN, a combinational path from wb_ready. Occupancy 0..1.
- All other requirements hold in both builds.

Structure
REQ-024 SHALL take the CSR address constants and the csr_wfunc encodings (01 write, 10 set, 11 clear) from the shared define package; no local redefinition.
REQ-025 SHALL implement the payload storage as one sub-module, ls_wb_entry: a payload register with load enable and clear, instantiated once or twice according to LS_WB_SKID_EN.

Verification
REQ-026 SHALL cover: lsu_valid=1 with lsu_PC=0x80000000 and wb_ready=1 -> next cycle LS_WB_reg_ls_valid=1 and LS_WB_reg_PC=0x80000000; one entry per cycle sustained for 10 cycles.
REQ-027 SHALL cover: wb_ready=0 for 5 cycles while three entries are offered -> with skid, 2 accepted and lsu_ready=0 from the third cycle; without skid, 1 accepted; head payload stable throughout; release delivers PCs in order.
REQ-028 SHALL cover: accept an entry with lsu_unusual_flag=1 and lsu_cause=2 -> trap_hold=1, lsu_ready=0, LS_WB_reg_cause=2 presented once; flush -> trap_hold=0 and lsu_ready=1 on the next cycle.
REQ-029 SHALL cover: flush coincident with lsu_valid=1 and a buffer of 2 -> LS_WB_reg_ls_valid=0 next cycle and the offered entry never appears downstream.
REQ-030 SHALL cover: rst_n pulsed low for half a cycle while full -> immediately LS_WB_reg_ls_valid=0, LS_WB_reg_CSR_wen=0, trap_hold=0, independent of clk.
